// File: rtl/retire_stage_pkg.sv
// Shared types for the commit end of the ROB: head-entry packet, retire FSM
// states and the packets the retire stage drives towards RF, map table and fetch.
package retire_stage_pkg;

   localparam int unsigned RT_ROB_SIZE = 32;
   localparam int unsigned RT_XLEN     = 32;
   localparam int unsigned RT_TAG_W    = $clog2(RT_ROB_SIZE);
   localparam int unsigned RT_REG_W    = 5;

   typedef struct packed {
      logic                valid;
      logic                cp_bit;
      logic                ep_bit;
      logic [RT_XLEN-1:0]  value;
      logic [RT_XLEN-1:0]  NPC;
      logic [RT_REG_W-1:0] reg_idx;
      logic [RT_XLEN-1:0]  PC;
   } ROB_ENTRY;

   typedef struct packed {
      ROB_ENTRY            rob_entry;
      logic [RT_TAG_W-1:0] Tag;
   } CP_RT_PACKET;

   typedef enum logic [1:0] {
      NORMAL,
      SQUASH,
      FLUSH
   } RT_STATE;

   typedef struct packed {
      logic                we;
      logic [RT_REG_W-1:0] idx;
      logic [RT_XLEN-1:0]  data;
   } RT_RF_PACKET;

   typedef struct packed {
      logic                valid;
      logic [RT_REG_W-1:0] idx;
      logic [RT_TAG_W-1:0] Tag;
   } RT_MT_PACKET;

   typedef struct packed {
      logic               valid;
      logic [RT_XLEN-1:0] pc;
   } RT_IF_PACKET;

endpackage

// File: rtl/retire_stage_if.sv
// Retire-stage bus: ROB head entry in, RF / map-table / fetch / dispatch
// control and debug outputs back. master = ROB side, slave = retire stage.
interface retire_stage_if
   import retire_stage_pkg::*;
#(
   parameter int unsigned ROB_SIZE = RT_ROB_SIZE,
   parameter int unsigned XLEN     = RT_XLEN,
   parameter int unsigned CNT_W    = 32
);

   localparam int unsigned TAG_W = $clog2(ROB_SIZE);

   CP_RT_PACKET       cp_rt_packet;
   logic              rf_we;
   logic [4:0]        rf_idx;
   logic [XLEN-1:0]   rf_data;
   logic              mt_clear_valid;
   logic [4:0]        mt_clear_idx;
   logic [TAG_W-1:0]  mt_clear_tag;
   logic              squash_signal;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              dispatch_stall;
   logic [CNT_W-1:0]  retire_count;
   logic [XLEN-1:0]   retired_pc;

   modport master (
      output cp_rt_packet,
      input  rf_we, rf_idx, rf_data,
      input  mt_clear_valid, mt_clear_idx, mt_clear_tag,
      input  squash_signal, redirect_valid, redirect_pc,
      input  dispatch_stall, retire_count, retired_pc
   );

   modport slave (
      input  cp_rt_packet,
      output rf_we, rf_idx, rf_data,
      output mt_clear_valid, mt_clear_idx, mt_clear_tag,
      output squash_signal, redirect_valid, redirect_pc,
      output dispatch_stall, retire_count, retired_pc
   );

endinterface

// File: rtl/retire_stage.sv
// In-order retire stage: commits the completed ROB head to the architectural
// RF, releases its map-table tag, and on a taken branch squashes the pipeline,
// redirects fetch and holds dispatch off for FLUSH_CYCLES cycles.
module retire_stage
   import retire_stage_pkg::*;
#(
   parameter int unsigned ROB_SIZE     = RT_ROB_SIZE,
   parameter int unsigned XLEN         = RT_XLEN,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 32
) (
   input  logic           clock,
   input  logic           reset,
   retire_stage_if.slave  rt
);

   // Packet widths come from the shared package; a differing override would
   // silently truncate the datapath.
   if (XLEN != RT_XLEN || ROB_SIZE != RT_ROB_SIZE) begin : g_width_guard
      $error("retire_stage: XLEN/ROB_SIZE must match retire_stage_pkg");
   end

   localparam int unsigned FC_W = $clog2(FLUSH_CYCLES + 1);
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

   RT_STATE           state_q, state_d;
   logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
   RT_RF_PACKET       rf_q, rf_d;
   RT_MT_PACKET       mt_q, mt_d;
   RT_IF_PACKET       if_q, if_d;
   logic              squash_q, squash_d;
   logic              stall_q, stall_d;
   logic [CNT_W-1:0]  retire_count_q, retire_count_d;
   logic [XLEN-1:0]   retired_pc_q, retired_pc_d;

   ROB_ENTRY          head;
   logic              retire;

   assign head   = rt.cp_rt_packet.rob_entry;
   assign retire = (state_q == NORMAL) && head.valid && head.cp_bit;

   // Next-state and next-output computation; outputs are derived from the
   // next state so they are registered alongside it.
   always_comb begin
      state_d        = state_q;
      flush_cnt_d    = flush_cnt_q;
      rf_d           = '{we: 1'b0, idx: rf_q.idx, data: rf_q.data};
      mt_d           = '{valid: 1'b0, idx: mt_q.idx, Tag: mt_q.Tag};
      if_d           = '{valid: 1'b0, pc: if_q.pc};
      retire_count_d = retire_count_q;
      retired_pc_d   = retired_pc_q;

      case (state_q)
         NORMAL: begin
            if (retire) begin
               rf_d.we        = (head.reg_idx != '0);
               rf_d.idx       = head.reg_idx;
               rf_d.data      = head.value;
               mt_d.valid     = 1'b1;
               mt_d.idx       = head.reg_idx;
               mt_d.Tag       = rt.cp_rt_packet.Tag;
               retired_pc_d   = head.PC;
               retire_count_d = retire_count_q + CNT_W'(1);
               if (head.ep_bit) begin
                  state_d    = SQUASH;
                  if_d.valid = 1'b1;
                  if_d.pc    = head.NPC;
               end
            end
         end
         SQUASH: begin
            state_d     = FLUSH;
            flush_cnt_d = FC_LOAD;
         end
         FLUSH: begin
            flush_cnt_d = flush_cnt_q - FC_W'(1);
            if (flush_cnt_q <= FC_W'(1)) begin
               state_d = NORMAL;
            end
         end
         default: begin
            state_d     = NORMAL;
            flush_cnt_d = '0;
         end
      endcase

      squash_d = (state_d == SQUASH);
      stall_d  = (state_d != NORMAL);
   end

   // FSM, flush counter and all registered outputs; synchronous reset wins
   // over any retire presented in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= NORMAL;
         flush_cnt_q    <= '0;
         rf_q           <= '0;
         mt_q           <= '0;
         if_q           <= '0;
         squash_q       <= 1'b0;
         stall_q        <= 1'b0;
         retire_count_q <= '0;
         retired_pc_q   <= '0;
      end else begin
         state_q        <= state_d;
         flush_cnt_q    <= flush_cnt_d;
         rf_q           <= rf_d;
         mt_q           <= mt_d;
         if_q           <= if_d;
         squash_q       <= squash_d;
         stall_q        <= stall_d;
         retire_count_q <= retire_count_d;
         retired_pc_q   <= retired_pc_d;
      end
   end

   assign rt.rf_we          = rf_q.we;
   assign rt.rf_idx         = rf_q.idx;
   assign rt.rf_data        = rf_q.data;
   assign rt.mt_clear_valid = mt_q.valid;
   assign rt.mt_clear_idx   = mt_q.idx;
   assign rt.mt_clear_tag   = mt_q.Tag;
   assign rt.squash_signal  = squash_q;
   assign rt.redirect_valid = if_q.valid;
   assign rt.redirect_pc    = if_q.pc;
   assign rt.dispatch_stall = stall_q;
   assign rt.retire_count   = retire_count_q;
   assign rt.retired_pc     = retired_pc_q;

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: two instances (32-bit and 4-bit retire
// counters) see identical head entries; a reference model queues the expected
// outputs for every cycle and a monitor pops and compares them.
module tb_retire_stage;
   import retire_stage_pkg::*;

   localparam int unsigned FC = 2;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   retire_stage_if #(.ROB_SIZE(32), .XLEN(32), .CNT_W(32)) rt_a ();
   retire_stage_if #(.ROB_SIZE(32), .XLEN(32), .CNT_W(4))  rt_b ();

   retire_stage #(.ROB_SIZE(32), .XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(32)) dut_a (
      .clock (clock),
      .reset (reset),
      .rt    (rt_a.slave)
   );

   retire_stage #(.ROB_SIZE(32), .XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(4)) dut_b (
      .clock (clock),
      .reset (reset),
      .rt    (rt_b.slave)
   );

   typedef struct {
      bit        rf_we;
      bit [4:0]  rf_idx;
      bit [31:0] rf_data;
      bit        mt_v;
      bit [4:0]  mt_idx;
      bit [4:0]  mt_tag;
      bit        squash;
      bit        redir_v;
      bit [31:0] redir_pc;
      bit        stall;
      bit [31:0] cnt;
      bit [31:0] ret_pc;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   busy;          // cycles still to come in which the head is ignored
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic CP_RT_PACKET mk(input bit v, input bit cp, input bit ep,
                                      input bit [31:0] value, input bit [31:0] npc,
                                      input bit [4:0] idx, input bit [31:0] pc,
                                      input bit [4:0] tag);
      CP_RT_PACKET p;
      p.rob_entry.valid   = v;
      p.rob_entry.cp_bit  = cp;
      p.rob_entry.ep_bit  = ep;
      p.rob_entry.value   = value;
      p.rob_entry.NPC     = npc;
      p.rob_entry.reg_idx = idx;
      p.rob_entry.PC      = pc;
      p.Tag               = tag;
      return p;
   endfunction

   function automatic CP_RT_PACKET rnd_pkt(input bit force_cp);
      bit [4:0] idx;
      idx = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom_range(31));
      return mk($urandom_range(7) != 0, force_cp | ($urandom_range(3) != 0),
                $urandom_range(7) == 0, $urandom, $urandom, idx, $urandom,
                5'($urandom_range(31)));
   endfunction

   // Reference behaviour: what the outputs must show in the cycle after this edge.
   task automatic model(input bit rst, input CP_RT_PACKET p);
      if (rst) begin
         cur  = '{default: '0};
         busy = 0;
      end else begin
         cur.rf_we   = 1'b0;
         cur.mt_v    = 1'b0;
         cur.squash  = 1'b0;
         cur.redir_v = 1'b0;
         if (busy > 0) begin
            busy--;
         end else if (p.rob_entry.valid && p.rob_entry.cp_bit) begin
            cur.rf_we   = (p.rob_entry.reg_idx != 0);
            cur.rf_idx  = p.rob_entry.reg_idx;
            cur.rf_data = p.rob_entry.value;
            cur.mt_v    = 1'b1;
            cur.mt_idx  = p.rob_entry.reg_idx;
            cur.mt_tag  = p.Tag;
            cur.ret_pc  = p.rob_entry.PC;
            cur.cnt     = cur.cnt + 1;
            if (p.rob_entry.ep_bit) begin
               busy         = 1 + FC;
               cur.squash   = 1'b1;
               cur.redir_v  = 1'b1;
               cur.redir_pc = p.rob_entry.NPC;
            end
         end
         cur.stall = (busy > 0);
      end
   endtask

   task automatic step(input bit rst, input CP_RT_PACKET p);
      reset             = rst;
      rt_a.cp_rt_packet = p;
      rt_b.cp_rt_packet = p;
      model(rst, p);
      exp_q.push_back(cur);
      @(posedge clock);
      #2;
   endtask

   // Monitor: every cycle, compare both instances against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rf_we",          32'(rt_a.rf_we),          32'(e.rf_we));
            chk("rf_idx",         32'(rt_a.rf_idx),         32'(e.rf_idx));
            chk("rf_data",        rt_a.rf_data,             e.rf_data);
            chk("mt_clear_valid", 32'(rt_a.mt_clear_valid), 32'(e.mt_v));
            chk("mt_clear_idx",   32'(rt_a.mt_clear_idx),   32'(e.mt_idx));
            chk("mt_clear_tag",   32'(rt_a.mt_clear_tag),   32'(e.mt_tag));
            chk("squash_signal",  32'(rt_a.squash_signal),  32'(e.squash));
            chk("redirect_valid", 32'(rt_a.redirect_valid), 32'(e.redir_v));
            chk("redirect_pc",    rt_a.redirect_pc,         e.redir_pc);
            chk("dispatch_stall", 32'(rt_a.dispatch_stall), 32'(e.stall));
            chk("retire_count",   rt_a.retire_count,        e.cnt);
            chk("retired_pc",     rt_a.retired_pc,          e.ret_pc);
            chk("c4_rf_we",       32'(rt_b.rf_we),          32'(e.rf_we));
            chk("c4_squash",      32'(rt_b.squash_signal),  32'(e.squash));
            chk("c4_stall",       32'(rt_b.dispatch_stall), 32'(e.stall));
            chk("c4_retire_count", 32'(rt_b.retire_count),  e.cnt & 32'hF);
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      CP_RT_PACKET idle;
      idle = mk(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 5'd0);
      cur  = '{default: '0};
      busy = 0;

      // Reset, then incomplete heads (even ones flagged as branches) never retire.
      step(1'b1, idle);
      step(1'b1, idle);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, mk(1'b1, 1'b0, i[0], $urandom, 32'h80, 5'(i + 1), $urandom, 5'(i)));
      end

      // Single retire, then an idle cycle so the pulses drop.
      step(1'b0, mk(1'b1, 1'b1, 1'b0, 32'hDEAD, 32'h104, 5'd5, 32'h100, 5'd3));
      step(1'b0, idle);

      // Three back-to-back retires, the middle one to x0.
      step(1'b0, mk(1'b1, 1'b1, 1'b0, 32'h1111, 32'h204, 5'd7, 32'h200, 5'd4));
      step(1'b0, mk(1'b1, 1'b1, 1'b0, 32'h2222, 32'h208, 5'd0, 32'h204, 5'd5));
      step(1'b0, mk(1'b1, 1'b1, 1'b0, 32'h3333, 32'h20C, 5'd9, 32'h208, 5'd6));
      step(1'b0, idle);

      // Mispredicted branch followed by completed (wrong-path / later) entries.
      step(1'b0, mk(1'b1, 1'b1, 1'b1, 32'h0BEE, 32'h80, 5'd1, 32'h300, 5'd8));
      for (int i = 0; i < 6; i++) begin
         step(1'b0, mk(1'b1, 1'b1, 1'b0, 32'h4000 + 32'(i), 32'h0, 5'(i + 10), 32'h304 + 32'(4 * i), 5'(9 + i)));
      end

      // Reset lands in FLUSH with a completed head present.
      step(1'b0, mk(1'b1, 1'b1, 1'b1, 32'h5555, 32'h400, 5'd2, 32'h3F0, 5'd1));
      step(1'b0, mk(1'b1, 1'b1, 1'b0, 32'h6666, 32'h0, 5'd3, 32'h3F4, 5'd2));
      step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h7777, 32'h0, 5'd4, 32'h3F8, 5'd3));
      step(1'b0, idle);

      // Reset in NORMAL beats a retire in the same cycle.
      step(1'b0, mk(1'b1, 1'b1, 1'b0, 32'h8888, 32'h0, 5'd6, 32'h500, 5'd7));
      step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h9999, 32'h0, 5'd8, 32'h504, 5'd8));

      // Sixteen straight retires: the 4-bit counter wraps to 0 on the last.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, mk(1'b1, 1'b1, 1'b0, $urandom, 32'h0, 5'($urandom_range(31)), 32'h600 + 32'(4 * i), 5'(i)));
      end

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(99) == 0, rnd_pkt(1'b0));
      end

      step(1'b0, idle);
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clock);
         #2;
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/retire_stage.md
# retire_stage

In-order retire stage at the commit end of the ROB interface. Each cycle it consumes the ROB head entry (`cp_rt_packet`). When that entry is complete, it commits the value to the architectural register file and tells the map table to release the tag. On a taken branch (fetch predicts not-taken) it drives a one-cycle `squash_signal` and a fetch redirect, then holds dispatch off for a fixed flush window.

## Interface
Parameters:
- `ROB_SIZE`, 32: ROB depth. Tag width is `$clog2(ROB_SIZE)`.
- `XLEN`, 32: data/PC width.
- `FLUSH_CYCLES`, 2: cycles dispatch is stalled after the squash cycle, ≥1.
- `CNT_W`, 32: retired-instruction counter width.

Ports:
- `clock` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `cp_rt_packet` in CP_RT_PACKET: ROB head entry.
  - Fields: `rob_entry.{valid, cp_bit, ep_bit, value, NPC, reg_idx, PC}`, `Tag`.
- `rf_we` out 1: architectural RF write enable.
- `rf_idx` out 5: RF write index.
- `rf_data` out XLEN: RF write data.
- `mt_clear_valid` out 1: map table releases `mt_clear_idx` if it still maps to `mt_clear_tag`.
- `mt_clear_idx` out 5: register to release.
- `mt_clear_tag` out `$clog2(ROB_SIZE)`: ROB tag being released.
- `squash_signal` out 1: flush ROB/RS/MT, one-cycle pulse.
- `redirect_valid` out 1: fetch redirect, coincident with `squash_signal`.
- `redirect_pc` out XLEN: redirect target.
- `dispatch_stall` out 1: dispatch must not allocate.
- `retire_count` out CNT_W: number of retired instructions.
- `retired_pc` out XLEN: PC of the last retired instruction (debug).

## Operation
- FSM states: NORMAL, SQUASH, FLUSH.
- Retire condition: state==NORMAL and `rob_entry.cp_bit`==1 and `rob_entry.valid`==1. The ROB advances its head in that same cycle.
- On retire, these are registered at the clock edge:
  - `rf_we`=(`reg_idx`!=0). No write when the destination is x0.
  - `rf_idx`=`reg_idx`, `rf_data`=`value`.
  - `mt_clear_valid`=1, `mt_clear_idx`=`reg_idx`, `mt_clear_tag`=`Tag`.
  - `retired_pc`=`PC`.
  - `retire_count`+=1, wrapping modulo 2^CNT_W.
- The retire pulses (`rf_we`, `mt_clear_valid`) last exactly one cycle. With no retire they return to 0. The data outputs hold their last value.
- NORMAL → SQUASH when the retiring entry has `ep_bit`=1. `redirect_pc` latches `NPC`. The branch's own RF write and count still happen; they are not squashed.
- SQUASH lasts one cycle:
  - `squash_signal`=`redirect_valid`=`dispatch_stall`=1.
  - Any head entry presented is ignored: no write, no count, no mt_clear. Younger completed entries the ROB pops this cycle are wrong-path.
  - SQUASH → FLUSH. A down-counter loads FLUSH_CYCLES.
- FLUSH: `dispatch_stall`=1 and inputs are ignored. The counter decrements each cycle. FLUSH → NORMAL after FLUSH_CYCLES cycles.
- In NORMAL, `dispatch_stall`=0.
- An entry with `cp_bit`=0 is never retired, whatever its other fields hold.

## Timing
- Retire latency: head entry complete in cycle N → `rf_we`/`mt_clear_valid`/count update visible in cycle N+1.
- Mispredict in cycle N:
  - Cycle N+1: `rf_we` for the branch, `squash_signal`, `redirect_valid`.
  - Cycles N+2 … N+1+FLUSH_CYCLES: `dispatch_stall` only.
  - Cycle N+2+FLUSH_CYCLES: first possible retire.
- Maximum throughput: one retire per cycle in NORMAL. Back-to-back retires produce back-to-back `rf_we` pulses.
- Reset values: state=NORMAL; all of these 0: `rf_we`, `rf_idx`, `rf_data`, `mt_clear_*`, `squash_signal`, `redirect_valid`, `redirect_pc`, `dispatch_stall`, `retire_count`, `retired_pc`, flush counter.
- Reset in SQUASH/FLUSH aborts the flush immediately. No residual squash pulse follows.
- Reset has priority over retire in the same cycle: nothing is committed.

## Structure
- Shared package additions:
  - `RT_STATE` enum {NORMAL, SQUASH, FLUSH}.
  - `RT_RF_PACKET` {we, idx, data}.
  - `RT_MT_PACKET` {valid, idx, Tag}.
  - `RT_IF_PACKET` {valid, pc}.
- Reuse the existing `CP_RT_PACKET`/`ROB_ENTRY` types unchanged.
- No sub-module: the FSM and flush counter stay in one module.

## Test plan
- Reset, then the head has `cp_bit`=0 for 5 cycles → no `rf_we`, `retire_count`=0, `dispatch_stall`=0.
- Head {cp_bit=1, reg_idx=5, value=0xDEAD, Tag=3} in cycle N → cycle N+1: `rf_we`=1, `rf_idx`=5, `rf_data`=0xDEAD, `mt_clear_tag`=3, `retire_count`=1. Cycle N+2: `rf_we`=0.
- Three consecutive complete entries, the second with reg_idx=0 → `rf_we` pattern 1,0,1; `mt_clear_valid` 1,1,1; `retire_count`=3.
- Branch {ep_bit=1, NPC=0x80, reg_idx=1} with FLUSH_CYCLES=2, followed by complete entries → `squash_signal` exactly one cycle with `redirect_pc`=0x80. `dispatch_stall` 3 cycles. No commits until NORMAL resumes; `retire_count` incremented only for the branch.
- Reset asserted during FLUSH → next cycle state NORMAL, `dispatch_stall`=0, `squash_signal`=0, counter 0.
- `retire_count` preloaded near 2^CNT_W−1 via 2^CNT_W−1 retires (CNT_W=4 build) → wraps to 0 on the 16th retire.
